weight_sum_backprop: RTL and testbench

//  Backward-pass partner of the forward W*X + U*h weighted-sum stage. It accepts one output-error

---
 rtl/lstm_fixed_pkg.sv | 51 +++++
 rtl/fx_mac_sat.sv | 53 +++++
 rtl/weight_sum_backprop.sv | 147 ++++++++++++++
 tb/tb_weight_sum_backprop.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_fixed_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lstm_fixed_pkg
// Brief    : Shared signed fixed-point types, constants and saturating helpers.
// Revision : 1.0  initial release
// ============================================================================
package lstm_fixed_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int FRACT_WIDTH = 8;

    localparam logic [DATA_WIDTH-1:0] ONE  = 16'h0100;
    localparam logic [DATA_WIDTH-1:0] ZERO = 16'h0000;

    typedef logic signed [DATA_WIDTH-1:0]   fx_t;
    typedef logic signed [2*DATA_WIDTH-1:0] fx_prod_t;

    // Clamp a 64-bit signed value into the signed range of a w-bit word (w <= 63).
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                        input int w);
        logic signed [63:0] w_hi;
        logic signed [63:0] w_lo;
        w_hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        w_lo = -(64'sd1 <<< (w - 1));
        if (v > w_hi)
            return w_hi;
        else if (v < w_lo)
            return w_lo;
        else
            return v;
    endfunction

    // Full-precision product realigned to the FRACT_WIDTH binary point.
    function automatic fx_prod_t fx_mul_shift(input fx_t a, input fx_t b);
        fx_prod_t w_p;
        w_p = fx_prod_t'(a) * fx_prod_t'(b);
        return w_p >>> FRACT_WIDTH;
    endfunction

    function automatic fx_t fx_mul_sat(input fx_t a, input fx_t b);
        fx_prod_t           w_s;
        logic signed [63:0] w_ext;
        logic signed [63:0] w_sat;
        w_s   = fx_mul_shift(a, b);
        w_ext = {{(64-2*DATA_WIDTH){w_s[2*DATA_WIDTH-1]}}, w_s};
        w_sat = sat_to_width(w_ext, DATA_WIDTH);
        return w_sat[DATA_WIDTH-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fx_mac_sat.sv
`default_nettype none
// ============================================================================
// Module   : fx_mac_sat
// Brief    : Error x weight saturated product plus saturating error x data
//            gradient accumulator (one per weight).
// Revision : 1.0  initial release
// ============================================================================
module fx_mac_sat
    import lstm_fixed_pkg::*;
#(
    parameter int ACC_WIDTH = 32    // must stay <= 62 so the 64-bit sum cannot wrap
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clr,
    input  logic                        i_en,
    input  fx_t                         i_err,
    input  fx_t                         i_data,
    input  fx_t                         i_weight,
    output fx_t                         o_prod_sat,
    output logic signed [ACC_WIDTH-1:0] o_acc
);

    localparam int c_PROD_W = 2 * DATA_WIDTH;

    logic signed [ACC_WIDTH-1:0] r_acc;
    fx_prod_t                    w_term;
    logic signed [63:0]          w_term_ext;
    logic signed [63:0]          w_acc_ext;
    logic signed [63:0]          w_sum;
    logic signed [63:0]          w_sum_sat;

    assign o_prod_sat = fx_mul_sat(i_weight, i_err);

    assign w_term     = fx_mul_shift(i_err, i_data);
    assign w_term_ext = {{(64-c_PROD_W){w_term[c_PROD_W-1]}}, w_term};
    assign w_acc_ext  = {{(64-ACC_WIDTH){r_acc[ACC_WIDTH-1]}}, r_acc};
    assign w_sum      = w_acc_ext + w_term_ext;
    assign w_sum_sat  = sat_to_width(w_sum, ACC_WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else if (i_en)
            r_acc <= w_sum_sat[ACC_WIDTH-1:0];
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/weight_sum_backprop.sv
`default_nettype none
// ============================================================================
// Module   : weight_sum_backprop
// Brief    : Backward pass of W*X + U*h: returns dX/dH per beat, accumulates
//            dW/dU over a sequence and applies one SGD step on the last beat.
// Revision : 1.0  initial release
// ============================================================================
module weight_sum_backprop
    import lstm_fixed_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int LR_SHIFT  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_x,
    input  logic [DATA_WIDTH-1:0] in_h,
    input  logic [DATA_WIDTH-1:0] in_grad,
    input  logic                  in_last,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] dx_out,
    output logic [DATA_WIDTH-1:0] dh_out,
    output logic [DATA_WIDTH-1:0] w_out,
    output logic [DATA_WIDTH-1:0] u_out,
    output logic                  upd_done
);

    localparam logic [0:0] c_ST_ACCUM  = 1'b0;
    localparam logic [0:0] c_ST_UPDATE = 1'b1;

    logic [0:0]                  r_state;
    logic                        r_live;
    fx_t                         r_w;
    fx_t                         r_u;
    fx_t                         r_dx;
    fx_t                         r_dh;
    logic                        r_out_valid;
    logic                        r_upd_done;

    logic                        w_accept;
    logic                        w_update;
    fx_t                         w_dx;
    fx_t                         w_dh;
    fx_t                         w_w_next;
    fx_t                         w_u_next;
    logic signed [ACC_WIDTH-1:0] w_dw_acc;
    logic signed [ACC_WIDTH-1:0] w_du_acc;

    // W <- sat(W - (acc >>> LR_SHIFT))
    function automatic fx_t sgd_step(input fx_t wt, input logic signed [ACC_WIDTH-1:0] g);
        logic signed [63:0] w_wt_ext;
        logic signed [63:0] w_g_ext;
        logic signed [63:0] w_diff;
        logic signed [63:0] w_sat;
        w_wt_ext = {{(64-DATA_WIDTH){wt[DATA_WIDTH-1]}}, wt};
        w_g_ext  = {{(64-ACC_WIDTH){g[ACC_WIDTH-1]}}, g};
        w_diff   = w_wt_ext - (w_g_ext >>> LR_SHIFT);
        w_sat    = sat_to_width(w_diff, DATA_WIDTH);
        return w_sat[DATA_WIDTH-1:0];
    endfunction

    // r_live holds in_ready low for the first cycle after reset releases.
    assign in_ready = r_live & (r_state == c_ST_ACCUM);
    assign w_accept = in_valid & in_ready;
    assign w_update = (r_state == c_ST_UPDATE);

    fx_mac_sat #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac_w (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_update),
        .i_en       (w_accept),
        .i_err      (in_grad),
        .i_data     (in_x),
        .i_weight   (r_w),
        .o_prod_sat (w_dx),
        .o_acc      (w_dw_acc)
    );

    fx_mac_sat #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac_u (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_update),
        .i_en       (w_accept),
        .i_err      (in_grad),
        .i_data     (in_h),
        .i_weight   (r_u),
        .o_prod_sat (w_dh),
        .o_acc      (w_du_acc)
    );

    assign w_w_next = sgd_step(r_w, w_dw_acc);
    assign w_u_next = sgd_step(r_u, w_du_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_ACCUM;
            r_live  <= 1'b0;
            r_w     <= ONE;
            r_u     <= ONE;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                c_ST_ACCUM: begin
                    if (w_accept && in_last)
                        r_state <= c_ST_UPDATE;
                end
                c_ST_UPDATE: begin
                    r_w     <= w_w_next;
                    r_u     <= w_u_next;
                    r_state <= c_ST_ACCUM;
                end
                default: r_state <= c_ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_upd_done  <= 1'b0;
            r_dx        <= ZERO;
            r_dh        <= ZERO;
        end else begin
            r_out_valid <= w_accept;
            r_upd_done  <= w_update;
            if (w_accept) begin
                r_dx <= w_dx;
                r_dh <= w_dh;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign dx_out    = r_dx;
    assign dh_out    = r_dh;
    assign w_out     = r_w;
    assign u_out     = r_u;
    assign upd_done  = r_upd_done;

endmodule
`default_nettype wire

// File: tb/tb_weight_sum_backprop.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_sum_backprop
// Brief    : Directed self-checking bench with a cycle-level arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
module tb_weight_sum_backprop;

    localparam int c_LR = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [15:0] in_x = '0;
    logic [15:0] in_h = '0;
    logic [15:0] in_grad = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] dx_out;
    logic [15:0] dh_out;
    logic [15:0] w_out;
    logic [15:0] u_out;
    logic        upd_done;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0;

    // model state: weights, gradient sums and expected registered outputs
    longint      m_w, m_u, m_dw, m_du;
    bit          m_upd, m_live, e_valid, e_upd;
    logic [15:0] e_dx, e_dh;

    weight_sum_backprop dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_h      (in_h),
        .in_grad   (in_grad),
        .in_last   (in_last),
        .out_valid (out_valid),
        .dx_out    (dx_out),
        .dh_out    (dh_out),
        .w_out     (w_out),
        .u_out     (u_out),
        .upd_done  (upd_done)
    );

    always #5 clk = ~clk;

    function automatic longint sat(input longint v, input int w);
        longint hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint fx_prod(input logic [15:0] a, input logic [15:0] b);
        return (longint'($signed(a)) * longint'($signed(b))) >>> 8;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_w = 256; m_u = 256; m_dw = 0; m_du = 0;
        m_upd = 0; m_live = 0; e_valid = 0; e_upd = 0;
        e_dx = '0; e_dh = '0;
    endtask

    // Compare DUT against the model every cycle, then predict the next cycle
    // from the inputs that will be sampled on the coming rising edge.
    initial begin
        bit take;
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            if (out_valid) pulse_cnt++;
            chk("in_ready",  {31'b0, in_ready},  {31'b0, m_live && !m_upd});
            chk("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
            chk("upd_done",  {31'b0, upd_done},  {31'b0, e_upd});
            chk("w_out",  {16'b0, w_out},  {16'b0, 16'(m_w)});
            chk("u_out",  {16'b0, u_out},  {16'b0, 16'(m_u)});
            chk("dx_out", {16'b0, dx_out}, {16'b0, e_dx});
            chk("dh_out", {16'b0, dh_out}, {16'b0, e_dh});
            if (!rst) begin
                take  = in_valid && m_live && !m_upd;
                e_upd = 0;
                if (m_upd) begin
                    m_w   = sat(m_w - (m_dw >>> c_LR), 16);
                    m_u   = sat(m_u - (m_du >>> c_LR), 16);
                    m_dw  = 0;
                    m_du  = 0;
                    m_upd = 0;
                    e_upd = 1;
                end
                e_valid = take;
                if (take) begin
                    e_dx = 16'(sat(fx_prod(16'(m_w), in_grad), 16));
                    e_dh = 16'(sat(fx_prod(16'(m_u), in_grad), 16));
                    m_dw = sat(m_dw + fx_prod(in_grad, in_x), 32);
                    m_du = sat(m_du + fx_prod(in_grad, in_h), 32);
                    if (in_last) m_upd = 1;
                end
                m_live = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Present a beat and hold it until the edge on which it is accepted.
    task automatic send(input logic [15:0] x, input logic [15:0] h,
                        input logic [15:0] g, input logic last);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_h     = h;
        in_grad  = g;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=%0b, expected 1 within 20 cycles", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;

        // reset state
        do_reset();
        chk("rst_w", {16'b0, w_out}, 32'h0100);
        chk("rst_u", {16'b0, u_out}, 32'h0100);
        chk("rst_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_dx", {16'b0, dx_out}, 32'h0000);

        // single non-last beat: latency 1, weights unchanged
        send(16'h0100, 16'h0080, 16'h0200, 1'b0);
        idle();
        chk("t2_valid", {31'b0, out_valid}, 32'd1);
        chk("t2_dx", {16'b0, dx_out}, 32'h0200);
        chk("t2_dh", {16'b0, dh_out}, 32'h0200);
        chk("t2_w", {16'b0, w_out}, 32'h0100);
        step();
        chk("t2_pulse", {31'b0, out_valid}, 32'd0);

        // one-beat sequence with update
        do_reset();
        send(16'h0100, 16'h0080, 16'h0100, 1'b1);
        idle();
        chk("t3_ready_upd", {31'b0, in_ready}, 32'd0);
        chk("t3_dx", {16'b0, dx_out}, 32'h0100);
        chk("t3_dh", {16'b0, dh_out}, 32'h0100);
        step();
        chk("t3_w", {16'b0, w_out}, 32'h00F0);
        chk("t3_u", {16'b0, u_out}, 32'h00F8);
        chk("t3_model_w", {16'b0, 16'(m_w)}, 32'h00F0);
        chk("t3_done", {31'b0, upd_done}, 32'd1);
        chk("t3_ready", {31'b0, in_ready}, 32'd1);
        step();
        chk("t3_done_pulse", {31'b0, upd_done}, 32'd0);

        // large gradient drives W to negative saturation
        do_reset();
        send(16'h7FFF, 16'h0000, 16'h7FFF, 1'b1);
        idle();
        chk("t4_dx", {16'b0, dx_out}, 32'h7FFF);
        step();
        chk("t4_w", {16'b0, w_out}, 32'h8000);
        chk("t4_u", {16'b0, u_out}, 32'h0100);

        // beat held across UPDATE is accepted exactly once
        do_reset();
        p0 = pulse_cnt;
        send(16'h0100, 16'h0080, 16'h0100, 1'b1);
        send(16'h0100, 16'h0100, 16'h0100, 1'b0);
        idle();
        chk("t5_dx", {16'b0, dx_out}, 32'h00F0);
        chk("t5_dh", {16'b0, dh_out}, 32'h00F8);
        step();
        chk("t5_pulses", 32'(pulse_cnt - p0), 32'd2);

        // reset mid-sequence discards partial gradients
        do_reset();
        for (int i = 0; i < 3; i++) send(16'h7000, 16'h7000, 16'h7000, 1'b0);
        idle();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("t6_w_rst", {16'b0, w_out}, 32'h0100);
        send(16'h0100, 16'h0080, 16'h0100, 1'b1);
        idle();
        step();
        chk("t6_w", {16'b0, w_out}, 32'h00F0);
        chk("t6_u", {16'b0, u_out}, 32'h00F8);

        // accumulator clamps instead of wrapping
        do_reset();
        for (int i = 0; i < 520; i++) send(16'h8000, 16'h0100, 16'h8000, (i == 519));
        idle();
        chk("t7_dx", {16'b0, dx_out}, 32'h8000);
        step();
        chk("t7_w", {16'b0, w_out}, 32'h8000);
        chk("t7_u", {16'b0, u_out}, 32'h7FFF);

        // dx/dh saturation with extreme weights
        send(16'h0000, 16'h0000, 16'h0200, 1'b0);
        idle();
        chk("t8_dx_neg", {16'b0, dx_out}, 32'h8000);
        chk("t8_dh_pos", {16'b0, dh_out}, 32'h7FFF);
        send(16'h0000, 16'h0000, 16'hFE00, 1'b0);
        idle();
        chk("t8_dx_pos", {16'b0, dx_out}, 32'h7FFF);
        chk("t8_dh_neg", {16'b0, dh_out}, 32'h8000);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
